// File: rtl/axi_arbiter.sv
// Two-client AXI read-address/read-response arbiter (IFU + LSU onto one master port).
// One burst is in flight at a time; ties in IDLE alternate against last_owner.
// Read data and response bypass this block; only the valid/ready/last handshake is steered.
module axi_arbiter (
    input  logic        clock,
    input  logic        reset,

    input  logic        ifu_arvalid,
    output logic        ifu_arready,
    input  logic [31:0] ifu_araddr,
    input  logic [7:0]  ifu_arlen,
    output logic        ifu_rvalid,
    input  logic        ifu_rready,

    input  logic        lsu_arvalid,
    output logic        lsu_arready,
    input  logic [31:0] lsu_araddr,
    input  logic [7:0]  lsu_arlen,
    input  logic [2:0]  lsu_arsize,
    output logic        lsu_rvalid,
    input  logic        lsu_rready,

    output logic        io_master_arvalid,
    input  logic        io_master_arready,
    output logic [31:0] io_master_araddr,
    output logic [7:0]  io_master_arlen,
    output logic [2:0]  io_master_arsize,
    output logic [1:0]  io_master_arburst,
    input  logic        io_master_rvalid,
    output logic        io_master_rready,
    input  logic        io_master_rlast
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

    localparam logic [2:0] IFU_SIZE   = 3'b010;
    localparam logic [1:0] BURST_INCR = 2'b01;

    state_t      state;
    owner_t      owner;
    owner_t      last_owner;
    logic        arvalid_q;
    logic [31:0] addr_q;
    logic [7:0]  len_q;
    logic [2:0]  size_q;

    logic        grant_ifu;
    logic        grant_lsu;
    logic        can_grant;
    logic        in_data;
    logic        beat_last;

    // Round-robin pick: LSU wins alone, or on a tie when IFU owned the previous burst.
    always_comb begin
        grant_lsu = lsu_arvalid && (!ifu_arvalid || (last_owner == OWN_IFU));
        grant_ifu = ifu_arvalid && !grant_lsu;
    end

    // Reset gates every combinational output so nothing handshakes during a reset cycle.
    assign can_grant   = (state == IDLE) && !reset;
    assign in_data     = (state == DATA) && !reset;

    assign ifu_arready = can_grant && grant_ifu;
    assign lsu_arready = can_grant && grant_lsu;

    assign io_master_rready = in_data && ((owner == OWN_IFU) ? ifu_rready : lsu_rready);
    assign ifu_rvalid       = in_data && (owner == OWN_IFU) && io_master_rvalid;
    assign lsu_rvalid       = in_data && (owner == OWN_LSU) && io_master_rvalid;
    assign beat_last        = io_master_rvalid && io_master_rready && io_master_rlast;

    assign io_master_arvalid = arvalid_q;
    assign io_master_araddr  = addr_q;
    assign io_master_arlen   = len_q;
    assign io_master_arsize  = size_q;
    assign io_master_arburst = arvalid_q ? BURST_INCR : 2'b00;

    // Sequencer: grant in IDLE, hold the request in ADDR, steer beats in DATA until rlast.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= OWN_IFU;
            last_owner <= OWN_IFU;
            arvalid_q  <= 1'b0;
            addr_q     <= 32'd0;
            len_q      <= 8'd0;
            size_q     <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_lsu) begin
                        owner     <= OWN_LSU;
                        addr_q    <= lsu_araddr;
                        len_q     <= lsu_arlen;
                        size_q    <= lsu_arsize;
                        arvalid_q <= 1'b1;
                        state     <= ADDR;
                    end else if (grant_ifu) begin
                        owner     <= OWN_IFU;
                        addr_q    <= ifu_araddr;
                        len_q     <= ifu_arlen;
                        size_q    <= IFU_SIZE;
                        arvalid_q <= 1'b1;
                        state     <= ADDR;
                    end
                end
                ADDR: begin
                    if (io_master_arready) begin
                        arvalid_q <= 1'b0;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    // Error responses do not end a burst early; only rlast does.
                    if (beat_last) begin
                        last_owner <= owner;
                        state      <= IDLE;
                    end
                end
                default: begin
                    arvalid_q <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_arbiter.sv
// Randomized bench for axi_arbiter: client/slave agents plus a transaction-level
// reference (bus busy/free, who asked, who finished last) checked every cycle.
module tb_axi_arbiter;

    logic        clock;
    logic        reset;
    logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
    logic [31:0] ifu_araddr;
    logic [7:0]  ifu_arlen;
    logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
    logic [31:0] lsu_araddr;
    logic [7:0]  lsu_arlen;
    logic [2:0]  lsu_arsize;
    logic        io_master_arvalid, io_master_arready;
    logic [31:0] io_master_araddr;
    logic [7:0]  io_master_arlen;
    logic [2:0]  io_master_arsize;
    logic [1:0]  io_master_arburst;
    logic        io_master_rvalid, io_master_rready, io_master_rlast;

    axi_arbiter dut (
        .clock(clock), .reset(reset),
        .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_araddr(ifu_araddr),
        .ifu_arlen(ifu_arlen), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
        .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready), .lsu_araddr(lsu_araddr),
        .lsu_arlen(lsu_arlen), .lsu_arsize(lsu_arsize), .lsu_rvalid(lsu_rvalid),
        .lsu_rready(lsu_rready),
        .io_master_arvalid(io_master_arvalid), .io_master_arready(io_master_arready),
        .io_master_araddr(io_master_araddr), .io_master_arlen(io_master_arlen),
        .io_master_arsize(io_master_arsize), .io_master_arburst(io_master_arburst),
        .io_master_rvalid(io_master_rvalid), .io_master_rready(io_master_rready),
        .io_master_rlast(io_master_rlast)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    localparam int C_IFU = 0;
    localparam int C_LSU = 1;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
    } req_t;

    // Agent state and knobs
    req_t q[2][$];
    logic pres[2];
    int   gnt_cnt[2];
    int   gnt_seen[2];
    int   req_pct, rvalid_pct, rready_pct, ar_stall, rready_low;
    int   stall_left, bp_left;
    logic rst_req;

    // Reference state: is the shared bus taken, is the address still pending, who finished last
    logic        m_busy, m_ar_pending, post_rst;
    int          m_owner, m_prev, m_left, obs_beats, n_done;
    logic [31:0] m_addr;
    logic [7:0]  m_len;
    logic [2:0]  m_size;
    int          glog[$];

    int n_chk, n_pass;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic push(input int c, input logic [31:0] a, input logic [7:0] l, input logic [2:0] s);
        req_t r;
        r.addr = a; r.len = l; r.size = s;
        q[c].push_back(r);
    endtask

    // Drive every DUT input for the coming cycle from agent state.
    task automatic drive();
        logic dp;
        reset = rst_req;
        for (int c = 0; c < 2; c++) begin
            if (gnt_cnt[c] != gnt_seen[c]) begin
                gnt_seen[c] = gnt_cnt[c];
                void'(q[c].pop_front());
                pres[c]    = 1'b0;
                stall_left = (ar_stall >= 0) ? ar_stall : $urandom_range(3);
                bp_left    = rready_low;
            end
            if (!pres[c] && q[c].size() > 0 && $urandom_range(99) < req_pct) pres[c] = 1'b1;
        end
        ifu_arvalid = pres[0];
        ifu_araddr  = pres[0] ? q[0][0].addr : $urandom;
        ifu_arlen   = pres[0] ? q[0][0].len  : 8'($urandom);
        lsu_arvalid = pres[1];
        lsu_araddr  = pres[1] ? q[1][0].addr : $urandom;
        lsu_arlen   = pres[1] ? q[1][0].len  : 8'($urandom);
        lsu_arsize  = pres[1] ? q[1][0].size : 3'($urandom);

        dp = m_busy && !m_ar_pending;
        if (m_ar_pending) begin
            if (stall_left > 0) begin io_master_arready = 1'b0; stall_left--; end
            else io_master_arready = 1'b1;
        end else io_master_arready = 1'($urandom_range(1));
        if (dp) begin
            io_master_rvalid = ($urandom_range(99) < rvalid_pct);
            io_master_rlast  = io_master_rvalid ? (m_left == 1) : 1'($urandom_range(1));
        end else begin
            io_master_rvalid = 1'($urandom_range(1));
            io_master_rlast  = 1'($urandom_range(1));
        end
        ifu_rready = ($urandom_range(99) < rready_pct);
        lsu_rready = ($urandom_range(99) < rready_pct);
        if (dp && bp_left > 0) begin
            if (m_owner == C_IFU) ifu_rready = 1'b0; else lsu_rready = 1'b0;
            bp_left--;
        end
    endtask

    // Compare outputs against the reference, then advance it across the coming edge.
    task automatic check_cycle();
        int   win;
        logic dp, own_rr, own_rv;
        if (reset) begin
            chk("rst_ifu_arready", ifu_arready, 0);
            chk("rst_lsu_arready", lsu_arready, 0);
            chk("rst_rready", io_master_rready, 0);
            chk("rst_ifu_rvalid", ifu_rvalid, 0);
            chk("rst_lsu_rvalid", lsu_rvalid, 0);
            m_busy = 1'b0; m_ar_pending = 1'b0; m_prev = C_IFU; post_rst = 1'b1;
            return;
        end
        if (post_rst) begin
            chk("post_rst_arvalid", io_master_arvalid, 0);
            chk("post_rst_araddr", io_master_araddr, 0);
            chk("post_rst_arlen", io_master_arlen, 0);
            chk("post_rst_arsize", io_master_arsize, 0);
            chk("post_rst_arburst", io_master_arburst, 0);
            post_rst = 1'b0;
        end
        win = -1;
        if (!m_busy) begin
            if (ifu_arvalid && lsu_arvalid) win = (m_prev == C_IFU) ? C_LSU : C_IFU;
            else if (lsu_arvalid) win = C_LSU;
            else if (ifu_arvalid) win = C_IFU;
        end
        chk("ifu_arready", ifu_arready, win == C_IFU);
        chk("lsu_arready", lsu_arready, win == C_LSU);
        chk("m_arvalid", io_master_arvalid, m_ar_pending);
        if (m_ar_pending) begin
            chk("m_araddr", io_master_araddr, m_addr);
            chk("m_arlen", io_master_arlen, m_len);
            chk("m_arsize", io_master_arsize, m_size);
            chk("m_arburst", io_master_arburst, 2'b01);
        end
        dp     = m_busy && !m_ar_pending;
        own_rr = (m_owner == C_IFU) ? ifu_rready : lsu_rready;
        own_rv = (m_owner == C_IFU) ? ifu_rvalid : lsu_rvalid;
        chk("m_rready", io_master_rready, dp ? own_rr : 1'b0);
        chk("ifu_rvalid", ifu_rvalid, (dp && m_owner == C_IFU) ? io_master_rvalid : 1'b0);
        chk("lsu_rvalid", lsu_rvalid, (dp && m_owner == C_LSU) ? io_master_rvalid : 1'b0);

        if (win >= 0) begin
            m_busy = 1'b1; m_ar_pending = 1'b1; m_owner = win;
            m_addr = (win == C_LSU) ? lsu_araddr : ifu_araddr;
            m_len  = (win == C_LSU) ? lsu_arlen  : ifu_arlen;
            m_size = (win == C_LSU) ? lsu_arsize : 3'd2;
            m_left = int'(m_len) + 1; obs_beats = 0;
            gnt_cnt[win]++;
            glog.push_back(win);
        end else if (m_ar_pending) begin
            if (io_master_arready) m_ar_pending = 1'b0;
        end else if (dp && io_master_rvalid && own_rr) begin
            if (own_rv) obs_beats++;
            m_left--;
            if (io_master_rlast) begin
                chk("beat_count", obs_beats, int'(m_len) + 1);
                m_busy = 1'b0; m_prev = m_owner; n_done++;
            end
        end
    endtask

    task automatic run1();
        @(posedge clock); #1;
        drive();
        @(negedge clock);
        check_cycle();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) run1();
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (n_done < target && n < budget) begin run1(); n++; end
        chk("done_count", n_done, target);
    endtask

    task automatic chk_order(input string tag, input int exp[]);
        chk({tag, "_len"}, glog.size(), exp.size());
        for (int i = 0; i < exp.size() && i < glog.size(); i++) chk(tag, glog[i], exp[i]);
    endtask

    task automatic do_reset(input int n);
        rst_req = 1'b1; run(n); rst_req = 1'b0;
    endtask

    initial begin
        int target;
        int ord2[];
        int ord4[];
        n_chk = 0; n_pass = 0; n_done = 0;
        reset = 1'b1; rst_req = 1'b1;
        ifu_arvalid = 0; ifu_araddr = 0; ifu_arlen = 0; ifu_rready = 0;
        lsu_arvalid = 0; lsu_araddr = 0; lsu_arlen = 0; lsu_arsize = 0; lsu_rready = 0;
        io_master_arready = 0; io_master_rvalid = 0; io_master_rlast = 0;
        pres[0] = 0; pres[1] = 0; gnt_cnt[0] = 0; gnt_cnt[1] = 0; gnt_seen[0] = 0; gnt_seen[1] = 0;
        req_pct = 100; rvalid_pct = 100; rready_pct = 100; ar_stall = 0; rready_low = 0;
        stall_left = 0; bp_left = 0;
        m_busy = 0; m_ar_pending = 0; m_prev = C_IFU; post_rst = 0; m_owner = C_IFU;
        m_left = 0; obs_beats = 0; m_addr = 0; m_len = 0; m_size = 0;

        do_reset(3);

        // IFU alone, 4-beat burst at 0x30000000
        glog.delete();
        push(C_IFU, 32'h3000_0000, 8'd3, 3'd0);
        wait_done(1, 100);
        ord2 = new[1]; ord2[0] = C_IFU;
        chk_order("ifu_only", ord2);
        run(2);

        // Tie straight after reset: LSU first, then IFU
        do_reset(2);
        glog.delete();
        push(C_LSU, 32'h8000_0100, 8'd2, 3'd3);
        push(C_IFU, 32'h3000_0040, 8'd1, 3'd0);
        wait_done(n_done + 2, 100);
        ord2 = new[2]; ord2[0] = C_LSU; ord2[1] = C_IFU;
        chk_order("tie_rst", ord2);

        // Both held busy for four bursts: strict alternation
        glog.delete();
        push(C_LSU, 32'h8000_0200, 8'd1, 3'd2);
        push(C_LSU, 32'h8000_0300, 8'd0, 3'd1);
        push(C_IFU, 32'h3000_0080, 8'd3, 3'd0);
        push(C_IFU, 32'h3000_00c0, 8'd2, 3'd0);
        wait_done(n_done + 4, 200);
        ord4 = new[4]; ord4[0] = C_LSU; ord4[1] = C_IFU; ord4[2] = C_LSU; ord4[3] = C_IFU;
        chk_order("b2b", ord4);

        // Slave holds arready low for 5 cycles
        ar_stall = 5;
        push(C_LSU, 32'h8000_0400, 8'd2, 3'd2);
        wait_done(n_done + 1, 100);
        ar_stall = 0;

        // Owner withholds rready for 3 data cycles
        rready_low = 3;
        push(C_IFU, 32'h3000_0100, 8'd3, 3'd0);
        wait_done(n_done + 1, 100);
        rready_low = 0;

        // Reset in the middle of an 8-beat burst
        push(C_LSU, 32'h8000_0500, 8'd7, 3'd2);
        begin
            int n = 0;
            while (!(m_busy && !m_ar_pending && obs_beats >= 2) && n < 100) begin run1(); n++; end
            chk("midburst_reached", obs_beats >= 2, 1);
        end
        do_reset(1);
        run(3);

        // Random traffic from both clients
        req_pct = 50; rvalid_pct = 60; rready_pct = 70; ar_stall = -1;
        for (int i = 0; i < 20; i++) begin
            push(C_IFU, $urandom, 8'($urandom_range(7)), 3'($urandom));
            push(C_LSU, $urandom, 8'($urandom_range(7)), 3'($urandom));
        end
        target = n_done + 40;
        wait_done(target, 20000);
        run(5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/axi_arbiter.md
AXI_ARBITER -- requirements
Module: axi_arbiter

Interface
REQ-001 The block SHALL have no parameters; widths are fixed at 32-bit address, 8-bit len, 3-bit size, 2-bit burst.
REQ-002 clock  input  1  single system clock, all state on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ifu_arvalid  input  1  IFU (ICACHE) read-address request.
REQ-005 ifu_arready  output  1  IFU request accepted this cycle.
REQ-006 ifu_araddr  input  32  IFU read address.
REQ-007 ifu_arlen  input  8  IFU burst length minus one.
REQ-008 ifu_rvalid  output  1  read beat valid to IFU.
REQ-009 ifu_rready  input  1  IFU accepts read beat.
REQ-010 lsu_arvalid  input  1  LSU read-address request.
REQ-011 lsu_arready  output  1  LSU request accepted this cycle.
REQ-012 lsu_araddr  input  32  LSU read address.
REQ-013 lsu_arlen  input  8  LSU burst length minus one.
REQ-014 lsu_arsize  input  3  LSU beat size.
REQ-015 lsu_rvalid  output  1  read beat valid to LSU.
REQ-016 lsu_rready  input  1  LSU accepts read beat.
REQ-017 io_master_arvalid  output  1  shared AXI read-address valid.
REQ-018 io_master_arready  input  1  slave address ready.
REQ-019 io_master_araddr  output  32  granted address.
REQ-020 io_master_arlen  output  8  granted burst length.
REQ-021 io_master_arsize  output  3  granted beat size.
REQ-022 io_master_arburst  output  2  burst type.
REQ-023 io_master_rvalid  input  1  slave read beat valid.
REQ-024 io_master_rready  output  1  read beat ready toward slave.
REQ-025 io_master_rlast  input  1  last beat of burst.
REQ-026 rdata/rresp SHALL NOT pass through this block; both clients take them directly from the slave.

Function
REQ-027 FSM states SHALL be IDLE, ADDR, DATA, plus owner register (IFU/LSU) and last_owner register.
REQ-028 In IDLE, a single requesting client SHALL be granted; with both requesting, the client not equal to last_owner SHALL win (round-robin).
REQ-029 Grant SHALL assert the winner's arready combinationally for exactly that IDLE cycle (T) and latch its addr/len/size; ifu_arready and lsu_arready SHALL never be high together.
REQ-030 io_master_arsize SHALL be latched lsu_arsize for LSU, 3'b010 for IFU; io_master_arburst SHALL be 2'b01 (INCR) whenever arvalid is high.
REQ-031 ADDR (entered T+1): io_master_arvalid=1 with araddr/arlen/arsize stable until io_master_arready; handshake cycle moves to DATA next cycle.
REQ-032 DATA: io_master_rready = owner's rready; owner's rvalid = io_master_rvalid; non-owner rvalid=0.
REQ-033 Beat with io_master_rvalid&&io_master_rready&&io_master_rlast SHALL move to IDLE and set last_owner<=owner; next grant no earlier than following cycle.
REQ-034 Non-owner arvalid asserted outside IDLE SHALL see arready=0 and wait; no request is dropped.
REQ-035 rresp error SHALL not alter sequencing; burst ends only on rlast.
REQ-036 Outside ADDR io_master_arvalid=0; outside DATA io_master_rready, ifu_rvalid, lsu_rvalid =0.

Reset
REQ-037 Reset SHALL force IDLE, last_owner=IFU (so LSU wins first tie), and all outputs 0, including mid-burst; beats still in flight are not accepted (rready=0).

Verification
REQ-038 IFU only: ifu_arvalid, araddr=0x30000000, arlen=3 -> ifu_arready at T, io_master_arvalid T+1 with addr 0x30000000, len 3, size 2; 4 beats to IFU, IDLE after rlast.
REQ-039 Simultaneous after reset: both arvalid -> LSU granted first; IFU granted in cycle after LSU rlast beat.
REQ-040 Back-to-back ties: both hold arvalid for 4 transactions -> grants alternate LSU, IFU, LSU, IFU.
REQ-041 arready stall: io_master_arready low 5 cycles -> arvalid/araddr/arlen constant throughout; DATA entered cycle after handshake.
REQ-042 rready backpressure and reset: owner rready low 3 cycles -> io_master_rready low, no beat lost; reset asserted mid-burst -> next cycle IDLE, all outputs 0.
